// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP transmit header + payload interface
// among PORTS requesters; a grant lasts from header acceptance to payload tlast.
module udp_tx_arbiter #(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned HDR_WIDTH  = 112,
    parameter int unsigned ID_WIDTH   = $clog2(PORTS)
) (
    input  logic                          clk,
    input  logic                          aresetn,

    input  logic [PORTS*HDR_WIDTH-1:0]    s_hdr_data,
    input  logic [PORTS-1:0]              s_hdr_valid,
    output logic [PORTS-1:0]              s_hdr_ready,

    input  logic [PORTS*DATA_WIDTH-1:0]   s_payload_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0]   s_payload_axis_tkeep,
    input  logic [PORTS-1:0]              s_payload_axis_tvalid,
    output logic [PORTS-1:0]              s_payload_axis_tready,
    input  logic [PORTS-1:0]              s_payload_axis_tlast,
    input  logic [PORTS-1:0]              s_payload_axis_tuser,

    output logic [HDR_WIDTH-1:0]          m_hdr_data,
    output logic                          m_hdr_valid,
    input  logic                          m_hdr_ready,

    output logic [DATA_WIDTH-1:0]         m_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_payload_axis_tkeep,
    output logic                          m_payload_axis_tvalid,
    input  logic                          m_payload_axis_tready,
    output logic                          m_payload_axis_tlast,
    output logic                          m_payload_axis_tuser,

    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          grant_active,
    output logic [31:0]                   pkt_count
);

    localparam int unsigned SUM_WIDTH = ID_WIDTH + 1;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(PORTS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ID_WIDTH-1:0]   rr_ptr;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  sel_found;
    logic [SUM_WIDTH-1:0]  cand;
    logic                  hdr_take;
    logic                  hdr_done;
    logic                  pkt_done;

    // Round-robin search: first valid header at or above rr_ptr, with wrap
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            cand = {1'b0, rr_ptr} + SUM_WIDTH'(i);
            if (cand >= SUM_WIDTH'(PORTS)) begin
                cand = cand - SUM_WIDTH'(PORTS);
            end
            if (!sel_found && s_hdr_valid[cand[ID_WIDTH-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = cand[ID_WIDTH-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus combinational ready/payload steering
    always_comb begin
        next_state            = state;
        hdr_take              = 1'b0;
        hdr_done              = 1'b0;
        pkt_done              = 1'b0;
        s_hdr_ready           = '0;
        s_payload_axis_tready = '0;
        m_payload_axis_tdata  = '0;
        m_payload_axis_tkeep  = '0;
        m_payload_axis_tvalid = 1'b0;
        m_payload_axis_tlast  = 1'b0;
        m_payload_axis_tuser  = 1'b0;
        case (state)
            IDLE: begin
                // Ready is gated by reset so no source sees a handshake while held in reset
                if (sel_found && aresetn) begin
                    s_hdr_ready[sel_id] = 1'b1;
                    hdr_take            = 1'b1;
                    next_state          = HDR;
                end
            end
            HDR: begin
                if (m_hdr_ready) begin
                    hdr_done   = 1'b1;
                    next_state = PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_payload_axis_tdata  = s_payload_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
                m_payload_axis_tkeep  = s_payload_axis_tkeep[grant_id*KEEP_WIDTH +: KEEP_WIDTH];
                m_payload_axis_tvalid = s_payload_axis_tvalid[grant_id];
                m_payload_axis_tlast  = s_payload_axis_tlast[grant_id];
                m_payload_axis_tuser  = s_payload_axis_tuser[grant_id];
                s_payload_axis_tready[grant_id] = m_payload_axis_tready;
                if (s_payload_axis_tvalid[grant_id] && m_payload_axis_tready &&
                    s_payload_axis_tlast[grant_id]) begin
                    pkt_done   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Header register, grant tracking, rr pointer advance and packet counter
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            m_hdr_data   <= '0;
            m_hdr_valid  <= 1'b0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            rr_ptr       <= '0;
            pkt_count    <= '0;
        end else begin
            if (hdr_take) begin
                m_hdr_data   <= s_hdr_data[sel_id*HDR_WIDTH +: HDR_WIDTH];
                m_hdr_valid  <= 1'b1;
                grant_id     <= sel_id;
                grant_active <= 1'b1;
            end
            if (hdr_done) begin
                m_hdr_valid <= 1'b0;
            end
            if (pkt_done) begin
                pkt_count    <= pkt_count + 32'd1;
                rr_ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
                grant_active <= 1'b0;
            end
        end
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UDP transmit user interface of fpga_core among PORTS requesters.
- The shared interface is the s_usr_hdr_* header channel plus the s_usr_payload_axis_* payload stream.
- Each requester presents a 112-bit UDP header followed by an AXI-Stream payload packet.
- The grant is held from header acceptance until the payload beat with tlast completes, so headers and payloads never interleave between sources.

Parameters:
- PORTS, 4, number of requesters (2..16).
- DATA_WIDTH, 64, payload tdata width.
- KEEP_WIDTH, DATA_WIDTH/8, payload tkeep width.
- HDR_WIDTH, 112, header width: {length[15:0], dest_port, src_port, dest_ip[31:0], src_ip[31:0]}.
- ID_WIDTH, $clog2(PORTS), grant index width.

Ports:
- clk  in  1  single clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_hdr_data  in  PORTS*HDR_WIDTH  per-port header; port i occupies slice i.
- s_hdr_valid  in  PORTS  header valid per port.
- s_hdr_ready  out  PORTS  header ready per port.
- s_payload_axis_tdata  in  PORTS*DATA_WIDTH  payload data.
- s_payload_axis_tkeep  in  PORTS*KEEP_WIDTH  payload byte keep.
- s_payload_axis_tvalid  in  PORTS  payload valid.
- s_payload_axis_tready  out  PORTS  payload ready.
- s_payload_axis_tlast  in  PORTS  payload last.
- s_payload_axis_tuser  in  PORTS  payload error flag.
- m_hdr_data  out  HDR_WIDTH  header to fpga_core s_usr_hdr_data.
- m_hdr_valid  out  1  header valid.
- m_hdr_ready  in  1  header ready.
- m_payload_axis_tdata/tkeep/tvalid/tlast/tuser  out  DATA_WIDTH/KEEP_WIDTH/1/1/1  muxed payload.
- m_payload_axis_tready  in  1  payload ready.
- grant_id  out  ID_WIDTH  port currently owning the output.
- grant_active  out  1  high while in HDR or PAYLOAD state.
- pkt_count  out  32  completed packets (tlast handshakes), wraps modulo 2^32.

Behaviour:
- Reset (aresetn low, asynchronous):
  - state=IDLE, rr pointer=0, grant_id=0, grant_active=0.
  - m_hdr_valid=0, m_hdr_data=0, pkt_count=0.
  - All s_hdr_ready=0, all s_payload_axis_tready=0, m_payload_axis_tvalid=0.
  - Reset mid-packet abandons the packet; no partial-packet recovery.
- FSM states are IDLE, HDR, PAYLOAD.
- IDLE:
  - Select the first port with s_hdr_valid set, searching from rr pointer upward with wrap.
  - In the same cycle, assert s_hdr_ready for that port only (combinational).
  - Register its header into m_hdr_data, latch grant_id, go to HDR.
  - m_hdr_valid=1 on the next cycle (1-cycle header latency).
  - No request: stay in IDLE, all readies 0.
- HDR:
  - Hold m_hdr_valid/m_hdr_data stable until m_hdr_ready.
  - On the handshake: m_hdr_valid=0, go to PAYLOAD.
  - Payload is not forwarded while in HDR.
- PAYLOAD:
  - Combinational pass-through from the granted port: m_payload_* = s_payload_*[grant_id].
  - s_payload_axis_tready[grant_id] = m_payload_axis_tready; all other tready=0.
  - tvalid gaps and backpressure pass through transparently.
  - On a beat with tvalid & tready & tlast: pkt_count+1, rr pointer = grant_id+1 (wrap to 0 past PORTS-1), go to IDLE.
- Outside PAYLOAD, m_payload_axis_tvalid=0.
- Back-to-back packets: one IDLE cycle after tlast before the next header is accepted. This bubble is required; do not bypass it.
- A header is always followed by at least one payload beat. A header-only packet is illegal.
- Non-granted ports see ready=0 and must hold their valid and data stable per AXI-Stream.
- Fairness: any continuously requesting port is granted within PORTS packets.
- pkt_count wraps 0xFFFFFFFF -> 0.

Test Plan:
- Single port 0: header {len 24, 1000->1234, 192.168.1.129->192.168.1.128} plus 2 beats 0x0f0f.., 0x0101..(tlast) -> m_hdr_valid one cycle after s_hdr_ready[0]; both beats appear unchanged; pkt_count=1; grant_active falls after tlast.
- Ports 0..3 all request continuously, 3 packets each -> grant order 0,1,2,3,0,1,2,3,...; no interleaving of beats; pkt_count=12.
- Hold m_hdr_ready low 5 cycles -> m_hdr_data stable, no payload tready; payload starts the cycle after the header handshake.
- m_payload_axis_tready toggled 1/0 and s tvalid gaps on the granted port -> only handshaked beats counted; data order preserved; other ports' tready stays 0.
- Assert aresetn low mid-PAYLOAD (after 1 of 3 beats) -> all outputs 0 immediately; after release, port 2 requesting alone is granted from pointer 0.
- Port 1 finishes tlast while ports 1 and 3 request -> one IDLE cycle, then port 3 is granted (pointer=2).
